// File: rtl/pid_filter.sv
// pid_filter -- velocity-form discrete PID stage.
//
// Computes u[n] = sat(u[n-1] + k1*e[n] + k2*e[n-1] + k3*e[n-2]) for each
// accepted sample, where e = setpoint - x. The coefficients are derived from
// the active gain registers:
//   k1 = p + i + d,   k2 = -p - 2d,   k3 = d.
// Frontpanel parameters are staged in shadow registers and promoted to the
// active set only while idle. This keeps every output built from a single
// parameter set.
//
// Ports:
//   clk_in          system clock
//   reset_in        synchronous active-high reset (datapath, FSM and params)
//   data_in         signed sample from the oversample filter
//   data_valid_in   one-cycle sample strobe; ignored while busy
//   setpoint_in     signed setpoint (frontpanel)
//   p/i/d_coef_in   signed gains (frontpanel)
//   activate_in     channel enable; low clears history, keeps parameters
//   update_en_in    qualifies update_in
//   update_in       pulse: capture frontpanel values into the shadows
//   data_out        signed PID output u, held between updates
//   data_valid_out  one-cycle pulse when data_out is new
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a sample; the only state where params may change
// ST_ERR   | form e0 = setpoint - x and shift the error history
// ST_PROD  | register the three coefficient * error products
// ST_SUM   | accumulate the products into u with saturation
// ST_SEND  | present data_valid_out for one cycle
module pid_filter #(
  parameter int W_DATA = 18,
  parameter int W_EP   = 16,
  parameter int W_OUT  = 48,
  parameter logic signed [W_EP-1:0] SETP_INIT = '0,
  parameter logic signed [W_EP-1:0] P_INIT    = '0,
  parameter logic signed [W_EP-1:0] I_INIT    = '0,
  parameter logic signed [W_EP-1:0] D_INIT    = '0
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic signed [W_DATA-1:0] data_in,
  input  logic                     data_valid_in,
  input  logic signed [W_EP-1:0]   setpoint_in,
  input  logic signed [W_EP-1:0]   p_coef_in,
  input  logic signed [W_EP-1:0]   i_coef_in,
  input  logic signed [W_EP-1:0]   d_coef_in,
  input  logic                     activate_in,
  input  logic                     update_en_in,
  input  logic                     update_in,
  output logic signed [W_OUT-1:0]  data_out,
  output logic                     data_valid_out
);

  localparam int W_E = W_DATA + 1;
  localparam int W_K = W_EP + 3;
  localparam int W_P = W_DATA + W_EP + 4;
  // The sum is kept two bits wider than the larger of u and a product so
  // that adding u and three products can never wrap before saturation,
  // even when the output is configured narrower than a product.
  localparam int W_S = ((W_OUT > W_P) ? W_OUT : W_P) + 2;

  localparam logic signed [W_S-1:0] U_MAX =
    {{(W_S-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_S-1:0] U_MIN =
    {{(W_S-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_PROD = 3'd2,
    ST_SUM  = 3'd3,
    ST_SEND = 3'd4
  } state_t;

  state_t state, state_next;

  logic pid_clear;
  logic accept;
  logic apply_params;

  logic signed [W_EP-1:0] setp_act, p_act, i_act, d_act;
  logic signed [W_EP-1:0] setp_shd, p_shd, i_shd, d_shd;
  logic                   pending;

  logic signed [W_K-1:0] p_ext, i_ext, d_ext;
  logic signed [W_K-1:0] k1, k2, k3;

  logic signed [W_DATA-1:0] x;
  logic signed [W_E-1:0]    e0, e1, e2;
  logic signed [W_E-1:0]    setp_e, x_e;
  logic signed [W_P-1:0]    prod1, prod2, prod3;
  logic signed [W_S-1:0]    sum;
  logic signed [W_OUT-1:0]  u, u_sat;

  assign pid_clear    = reset_in | ~activate_in;
  assign accept       = (state == ST_IDLE) && data_valid_in && !pid_clear;
  assign apply_params = pending && (state == ST_IDLE) && !accept;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in) begin
    if (pid_clear) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (data_valid_in) state_next = ST_ERR;
      ST_ERR:  state_next = ST_PROD;
      ST_PROD: state_next = ST_SUM;
      ST_SUM:  state_next = ST_SEND;
      ST_SEND: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- parameter registers ----------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      setp_act <= SETP_INIT;
      p_act    <= P_INIT;
      i_act    <= I_INIT;
      d_act    <= D_INIT;
      setp_shd <= SETP_INIT;
      p_shd    <= P_INIT;
      i_shd    <= I_INIT;
      d_shd    <= D_INIT;
      pending  <= 1'b0;
    end else begin
      if (apply_params) begin
        setp_act <= setp_shd;
        p_act    <= p_shd;
        i_act    <= i_shd;
        d_act    <= d_shd;
        pending  <= 1'b0;
      end
      // A fresh update wins over a promotion in the same cycle: the old
      // shadows move to active and the new ones stay pending.
      if (update_in && update_en_in) begin
        setp_shd <= setpoint_in;
        p_shd    <= p_coef_in;
        i_shd    <= i_coef_in;
        d_shd    <= d_coef_in;
        pending  <= 1'b1;
      end
    end
  end

  // ---------------- coefficients ----------------
  always_comb begin
    p_ext = {{3{p_act[W_EP-1]}}, p_act};
    i_ext = {{3{i_act[W_EP-1]}}, i_act};
    d_ext = {{3{d_act[W_EP-1]}}, d_act};
    k1    = p_ext + i_ext + d_ext;
    k2    = -p_ext - (d_ext <<< 1);
    k3    = d_ext;
  end

  // ---------------- datapath ----------------
  always_comb begin
    setp_e = {{(W_E-W_EP){setp_act[W_EP-1]}}, setp_act};
    x_e    = {x[W_DATA-1], x};
    sum    = W_S'(u) + W_S'(prod1) + W_S'(prod2) + W_S'(prod3);
    if (sum > U_MAX)      u_sat = U_MAX[W_OUT-1:0];
    else if (sum < U_MIN) u_sat = U_MIN[W_OUT-1:0];
    else                  u_sat = sum[W_OUT-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (pid_clear) begin
      x     <= '0;
      e0    <= '0;
      e1    <= '0;
      e2    <= '0;
      prod1 <= '0;
      prod2 <= '0;
      prod3 <= '0;
      u     <= '0;
    end else begin
      if (accept) x <= data_in;
      if (state == ST_ERR) begin
        e0 <= setp_e - x_e;
        e1 <= e0;
        e2 <= e1;
      end
      if (state == ST_PROD) begin
        prod1 <= W_P'(k1) * W_P'(e0);
        prod2 <= W_P'(k2) * W_P'(e1);
        prod3 <= W_P'(k3) * W_P'(e2);
      end
      if (state == ST_SUM) u <= u_sat;
    end
  end

  // Outputs are forced low combinationally so a clear takes effect in the
  // same cycle it is asserted, not one cycle later.
  assign data_out       = pid_clear ? '0 : u;
  assign data_valid_out = (state == ST_SEND) && !pid_clear;

endmodule

// File: tb/tb_pid_filter.sv
module tb_pid_filter;

  localparam int W_DATA = 18;
  localparam int W_EP   = 16;
  localparam int W_OUT  = 20;

  logic                     clk_in = 1'b0;
  logic                     reset_in;
  logic signed [W_DATA-1:0] data_in;
  logic                     data_valid_in;
  logic signed [W_EP-1:0]   setpoint_in, p_coef_in, i_coef_in, d_coef_in;
  logic                     activate_in, update_en_in, update_in;
  logic signed [W_OUT-1:0]  data_out;
  logic                     data_valid_out;

  pid_filter #(
    .W_DATA(W_DATA), .W_EP(W_EP), .W_OUT(W_OUT),
    .SETP_INIT(16'sd10), .P_INIT(16'sd2), .I_INIT(16'sd0), .D_INIT(16'sd0)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .data_in(data_in), .data_valid_in(data_valid_in),
    .setpoint_in(setpoint_in), .p_coef_in(p_coef_in),
    .i_coef_in(i_coef_in), .d_coef_in(d_coef_in),
    .activate_in(activate_in), .update_en_in(update_en_in),
    .update_in(update_in),
    .data_out(data_out), .data_valid_out(data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic signed [W_OUT-1:0] val;
    int                      cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: every output pulse must match the oldest expectation in value
  // and in arrival cycle.
  always @(negedge clk_in) begin
    if (data_valid_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid cycle %0d data_out %0d", cyc, data_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (data_out !== e.val) begin
          errors++;
          $display("FAIL out_value got %0d expected %0d", data_out, e.val);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL out_latency got cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check_out(input string name, input logic signed [W_OUT-1:0] exp);
    checks++;
    if (data_out !== exp || data_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL %s data_out %0d valid %0b expected %0d valid 0",
               name, data_out, data_valid_out, exp);
    end
  endtask

  // One sample; output expected 4 cycles later, then held.
  task automatic send(input logic signed [W_DATA-1:0] d,
                      input logic signed [W_OUT-1:0] exp);
    exp_t e;
    data_in       = d;
    data_valid_in = 1'b1;
    e.val = exp;
    e.cyc = cyc + 4;
    q.push_back(e);
    tick(1);
    data_valid_in = 1'b0;
    update_in     = 1'b0;
    update_en_in  = 1'b0;
    tick(6);
    check_out("hold", exp);
  endtask

  task automatic upd(input logic signed [W_EP-1:0] sp, p, i, d);
    setpoint_in  = sp;
    p_coef_in    = p;
    i_coef_in    = i;
    d_coef_in    = d;
    update_en_in = 1'b1;
    update_in    = 1'b1;
    tick(1);
    update_in    = 1'b0;
    update_en_in = 1'b0;
    tick(2);
  endtask

  task automatic deactivate();
    activate_in = 1'b0;
    #1;
    check_out("clear", '0);
    tick(1);
    activate_in = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in      = 1'b1;
    activate_in   = 1'b1;
    data_in       = '0;
    data_valid_in = 1'b0;
    setpoint_in   = '0;
    p_coef_in     = '0;
    i_coef_in     = '0;
    d_coef_in     = '0;
    update_en_in  = 1'b0;
    update_in     = 1'b0;
    tick(3);
    check_out("reset", '0);
    reset_in = 1'b0;
    tick(2);

    // Init params: setpoint 10, p 2 -> e = 6, u = 12
    send(18'sd4, 20'sd12);
    deactivate();

    // P-only
    upd(16'sd100, 16'sd1, 16'sd0, 16'sd0);
    send(18'sd40, 20'sd60);
    send(18'sd40, 20'sd60);
    send(18'sd40, 20'sd60);
    deactivate();

    // I-only, then clear keeps gains but drops history
    upd(16'sd100, 16'sd0, 16'sd1, 16'sd0);
    send(18'sd40, 20'sd60);
    send(18'sd40, 20'sd120);
    send(18'sd40, 20'sd180);
    deactivate();
    send(18'sd40, 20'sd60);
    deactivate();

    // D-only
    upd(16'sd100, 16'sd0, 16'sd0, 16'sd1);
    send(18'sd40, 20'sd60);
    send(18'sd40, 20'sd0);
    send(18'sd40, 20'sd0);
    send(18'sd50, -20'sd10);
    deactivate();

    // Update coinciding with an accepted sample uses the old gain
    upd(16'sd100, 16'sd0, 16'sd1, 16'sd0);
    send(18'sd40, 20'sd60);
    i_coef_in    = 16'sd2;
    update_en_in = 1'b1;
    update_in    = 1'b1;
    send(18'sd40, 20'sd120);
    send(18'sd40, 20'sd240);
    // update without enable is ignored
    i_coef_in    = 16'sd5;
    update_en_in = 1'b0;
    update_in    = 1'b1;
    tick(1);
    update_in    = 1'b0;
    tick(2);
    send(18'sd40, 20'sd360);
    deactivate();

    // Saturation at +/- full scale of a 20-bit output
    upd(16'sd32767, 16'sd0, 16'sd32767, 16'sd0);
    send(-18'sd131072, 20'sd524287);
    send(-18'sd131072, 20'sd524287);
    upd(-16'sd32768, 16'sd0, 16'sd32767, 16'sd0);
    send(18'sd131071, -20'sd524288);
    send(18'sd131071, -20'sd524288);
    deactivate();

    // Busy drop: second pulse 2 cycles later is ignored
    upd(16'sd100, 16'sd1, 16'sd0, 16'sd0);
    begin
      exp_t e;
      data_in       = 18'sd40;
      data_valid_in = 1'b1;
      e.val = 20'sd60;
      e.cyc = cyc + 4;
      q.push_back(e);
      tick(1);
      data_valid_in = 1'b0;
      tick(1);
      data_in       = 18'sd0;
      data_valid_in = 1'b1;
      tick(1);
      data_valid_in = 1'b0;
      tick(8);
      check_out("busy_hold", 20'sd60);
    end

    // Reset while in ST_PROD: no output pulse, outputs zero, params to init
    data_in       = 18'sd40;
    data_valid_in = 1'b1;
    tick(1);
    data_valid_in = 1'b0;
    tick(1);
    reset_in = 1'b1;
    #1;
    check_out("reset_mid", '0);
    tick(1);
    reset_in = 1'b0;
    #1;
    check_out("after_reset", '0);
    tick(6);
    send(18'sd4, 20'sd12);

    tick(4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs got %0d pending expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
